// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, oversample counts and
// data-bits configuration encoding (common to receiver and transmitter).
package uart_pkg;

  localparam int UART_OVERSAMPLE = 16;
  localparam logic [3:0] CNT_MID_START = 4'd7;
  localparam logic [3:0] CNT_SAMPLE    = 4'd15;

  localparam logic [1:0] DATA_BITS_5 = 2'b00;
  localparam logic [1:0] DATA_BITS_6 = 2'b01;
  localparam logic [1:0] DATA_BITS_7 = 2'b10;
  localparam logic [1:0] DATA_BITS_8 = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_WAIT_IDLE
  } uart_rx_state_t;

  // Index of the last data bit for a given data-bits setting.
  function automatic logic [2:0] last_bit_idx(input logic [1:0] cfg);
    case (cfg)
      DATA_BITS_5: last_bit_idx = 3'd4;
      DATA_BITS_6: last_bit_idx = 3'd5;
      DATA_BITS_7: last_bit_idx = 3'd6;
      default:     last_bit_idx = 3'd7;
    endcase
  endfunction

endpackage

// File: rtl/uart_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module uart_sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta_q, sync_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d;
      sync_q <= meta_q;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 16x-oversampled UART receiver, 5-8 data bits, optional parity, one stop bit,
// valid/ready delivery with parity, framing and overrun flags.
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int OVERSAMPLE = UART_OVERSAMPLE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx_tick,
  input  logic                  rxd,
  input  logic [1:0]            cfg_data_bits,
  input  logic                  cfg_parity_en,
  input  logic                  cfg_parity_odd,
  input  logic                  rx_ready,
  output logic                  rx_valid,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  overrun_err,
  output logic                  rx_busy
);

  logic rxs;

  uart_sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rxd),
    .q   (rxs)
  );

  uart_rx_state_t        state_q, state_d;
  logic [3:0]            cnt_q, cnt_d, cnt_inc;
  logic [2:0]            bit_idx_q, bit_idx_d;
  logic [2:0]            last_idx_q, last_idx_d;
  logic                  par_en_q, par_en_d;
  logic                  par_odd_q, par_odd_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  perr_q, perr_d;
  logic                  valid_q, valid_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  parity_err_q, parity_err_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_q, overrun_d;
  logic                  done;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_idx_d  = bit_idx_q;
    last_idx_d = last_idx_q;
    par_en_d   = par_en_q;
    par_odd_d  = par_odd_q;
    shift_d    = shift_q;
    perr_d     = perr_q;
    done       = 1'b0;
    cnt_inc    = (cnt_q == 4'(OVERSAMPLE - 1)) ? 4'd0 : cnt_q + 4'd1;

    if (rx_tick) begin
      case (state_q)
        ST_IDLE: begin
          // Configuration is captured here and held for the whole frame.
          if (!rxs) begin
            state_d    = ST_START;
            cnt_d      = 4'd0;
            last_idx_d = last_bit_idx(cfg_data_bits);
            par_en_d   = cfg_parity_en;
            par_odd_d  = cfg_parity_odd;
            shift_d    = '0;
            perr_d     = 1'b0;
          end
        end
        ST_START: begin
          if (cnt_q == CNT_MID_START) begin
            cnt_d     = 4'd0;
            bit_idx_d = 3'd0;
            state_d   = rxs ? ST_IDLE : ST_DATA;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        ST_DATA: begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_SAMPLE) begin
            shift_d[bit_idx_q] = rxs;
            if (bit_idx_q == last_idx_q) state_d = par_en_q ? ST_PARITY : ST_STOP;
            else                         bit_idx_d = bit_idx_q + 3'd1;
          end
        end
        ST_PARITY: begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_SAMPLE) begin
            perr_d  = ((^shift_q) ^ rxs) != par_odd_q;
            state_d = ST_STOP;
          end
        end
        ST_STOP: begin
          cnt_d = cnt_inc;
          if (cnt_q == CNT_SAMPLE) begin
            done    = 1'b1;
            state_d = rxs ? ST_IDLE : ST_WAIT_IDLE;
          end
        end
        ST_WAIT_IDLE: if (rxs) state_d = ST_IDLE;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // A completion on the same clk as a consume reloads instead of overrunning.
  always_comb begin
    valid_d      = valid_q;
    data_d       = data_q;
    parity_err_d = parity_err_q;
    frame_err_d  = frame_err_q;
    overrun_d    = 1'b0;
    if (done) begin
      if (!valid_q || rx_ready) begin
        valid_d      = 1'b1;
        data_d       = shift_q;
        parity_err_d = perr_q;
        frame_err_d  = !rxs;
      end else begin
        overrun_d = 1'b1;
      end
    end else if (valid_q && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 4'd0;
      bit_idx_q    <= 3'd0;
      last_idx_q   <= 3'd7;
      par_en_q     <= 1'b0;
      par_odd_q    <= 1'b0;
      shift_q      <= '0;
      perr_q       <= 1'b0;
      valid_q      <= 1'b0;
      data_q       <= '0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      bit_idx_q    <= bit_idx_d;
      last_idx_q   <= last_idx_d;
      par_en_q     <= par_en_d;
      par_odd_q    <= par_odd_d;
      shift_q      <= shift_d;
      perr_q       <= perr_d;
      valid_q      <= valid_d;
      data_q       <= data_d;
      parity_err_q <= parity_err_d;
      frame_err_q  <= frame_err_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rx_valid    = valid_q;
  assign rx_data     = data_q;
  assign parity_err  = parity_err_q;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_q;
  assign rx_busy     = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: table of frame vectors plus hand-written corner sequences;
// expected frames go through a queue scoreboard checked on each rx_valid rise.
module tb_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_tick = 1'b0;
  logic       rxd = 1'b1;
  logic [1:0] cfg_data_bits = 2'b11;
  logic       cfg_parity_en = 1'b0;
  logic       cfg_parity_odd = 1'b0;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       parity_err, frame_err, overrun_err, rx_busy;

  uart_rx #(.DATA_WIDTH(8), .OVERSAMPLE(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .rx_tick        (rx_tick),
    .rxd            (rxd),
    .cfg_data_bits  (cfg_data_bits),
    .cfg_parity_en  (cfg_parity_en),
    .cfg_parity_odd (cfg_parity_odd),
    .rx_ready       (rx_ready),
    .rx_valid       (rx_valid),
    .rx_data        (rx_data),
    .parity_err     (parity_err),
    .frame_err      (frame_err),
    .overrun_err    (overrun_err),
    .rx_busy        (rx_busy)
  );

  always #5 clk = ~clk;

  // rx_tick: one clk in every four, so one bit period is 64 clk.
  int tdiv = 0;
  always @(negedge clk) begin
    tdiv    = (tdiv + 1) % 4;
    rx_tick = (tdiv == 0);
  end

  typedef struct {
    logic [7:0] d;
    logic       perr;
    logic       ferr;
  } exp_t;

  typedef struct {
    logic [1:0] bits;
    logic       pen;
    logic       podd;
    logic       pbit;
    logic [7:0] d;
    logic [7:0] exp_d;
    logic       exp_perr;
  } vec_t;

  exp_t  sb[$];
  vec_t  vecs[8];
  int    checks = 0;
  int    errors = 0;
  int    frames_seen = 0;
  int    ovr_seen = 0;
  int    run = 0;
  int    last_run = 0;
  logic  prev_valid = 1'b0;
  time   rise_t = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (rx_valid && !prev_valid) begin
      exp_t e;
      frames_seen++;
      rise_t = $time;
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got data %0h expected no frame", rx_data);
      end else begin
        e = sb.pop_front();
        chk("frame_data", 32'(rx_data), 32'(e.d));
        chk("frame_parity_err", 32'(parity_err), 32'(e.perr));
        chk("frame_frame_err", 32'(frame_err), 32'(e.ferr));
      end
    end
    if (overrun_err) ovr_seen++;
    if (rx_valid) begin
      run++;
      last_run = run;
    end else begin
      run = 0;
    end
    prev_valid = rx_valid;
  end

  task automatic bit_time(input logic v);
    rxd = v;
    repeat (64) @(negedge clk);
  endtask

  // Drives start, data LSB first, optional parity and stop; leaves rxd at stop level.
  task automatic send(input logic [7:0] d, input int nb, input logic pen,
                      input logic pbit, input logic stop);
    bit_time(1'b0);
    for (int i = 0; i < nb; i++) bit_time(d[i]);
    if (pen) bit_time(pbit);
    bit_time(stop);
  endtask

  task automatic push(input logic [7:0] d, input logic perr, input logic ferr);
    exp_t e;
    e.d = d; e.perr = perr; e.ferr = ferr;
    sb.push_back(e);
  endtask

  initial begin
    int   f0, o0;
    time  t0;
    vecs[0] = '{2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{2'b10, 1'b1, 1'b0, 1'b0, 8'h35, 8'h35, 1'b0};
    vecs[2] = '{2'b10, 1'b1, 1'b0, 1'b1, 8'h35, 8'h35, 1'b1};
    vecs[3] = '{2'b00, 1'b1, 1'b1, 1'b1, 8'h1B, 8'h1B, 1'b0};
    vecs[4] = '{2'b01, 1'b1, 1'b1, 1'b1, 8'h2A, 8'h2A, 1'b1};
    vecs[5] = '{2'b11, 1'b1, 1'b0, 1'b0, 8'hFF, 8'hFF, 1'b0};
    vecs[6] = '{2'b00, 1'b0, 1'b0, 1'b0, 8'hFF, 8'h1F, 1'b0};
    vecs[7] = '{2'b01, 1'b1, 1'b0, 1'b1, 8'h07, 8'h07, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_valid", 32'(rx_valid), 0);
    chk("reset_data", 32'(rx_data), 0);
    chk("reset_flags", {29'd0, parity_err, frame_err, overrun_err}, 0);
    chk("reset_busy", 32'(rx_busy), 0);
    rst = 1'b0;
    repeat (20) @(negedge clk);

    // 8N1 0xA5: latency, one-clk valid pulse, data held after consumption.
    push(8'hA5, 1'b0, 1'b0);
    t0 = $time;
    send(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    repeat (64) @(negedge clk);
    chk("a5_latency_window", 32'((rise_t - t0) / 10 >= 600 && (rise_t - t0) / 10 <= 616), 1);
    chk("a5_valid_one_clk", 32'(last_run), 1);
    chk("a5_valid_low", 32'(rx_valid), 0);
    chk("a5_data_held", 32'(rx_data), 32'h A5);

    for (int i = 0; i < 8; i++) begin
      cfg_data_bits  = vecs[i].bits;
      cfg_parity_en  = vecs[i].pen;
      cfg_parity_odd = vecs[i].podd;
      push(vecs[i].exp_d, vecs[i].exp_perr, 1'b0);
      f0 = frames_seen;
      send(vecs[i].d, 5 + int'(vecs[i].bits), vecs[i].pen, vecs[i].pbit, 1'b1);
      repeat (64) @(negedge clk);
      chk("vec_frame_count", 32'(frames_seen - f0), 1);
      chk("vec_idle", 32'(rx_busy), 0);
    end

    cfg_data_bits = 2'b11; cfg_parity_en = 1'b0; cfg_parity_odd = 1'b0;

    // False start: 5 ticks low.
    f0 = frames_seen;
    rxd = 1'b0;
    repeat (12) @(negedge clk);
    chk("glitch_busy", 32'(rx_busy), 1);
    repeat (8) @(negedge clk);
    rxd = 1'b1;
    repeat (100) @(negedge clk);
    chk("glitch_idle", 32'(rx_busy), 0);
    chk("glitch_no_frame", 32'(frames_seen - f0), 0);

    // Break: stop bit low, line held low 40 ticks.
    push(8'h00, 1'b0, 1'b1);
    f0 = frames_seen;
    send(8'h00, 8, 1'b0, 1'b0, 1'b0);
    repeat (160) @(negedge clk);
    chk("break_busy", 32'(rx_busy), 1);
    chk("break_one_frame", 32'(frames_seen - f0), 1);
    rxd = 1'b1;
    repeat (128) @(negedge clk);
    chk("break_idle", 32'(rx_busy), 0);
    chk("break_no_refire", 32'(frames_seen - f0), 1);

    // Overrun: consumer stalled across two back-to-back frames.
    rx_ready = 1'b0;
    push(8'h11, 1'b0, 1'b0);
    f0 = frames_seen; o0 = ovr_seen;
    send(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send(8'h22, 8, 1'b0, 1'b0, 1'b1);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
    chk("ovr_data_kept", 32'(rx_data), 32'h11);
    chk("ovr_valid_held", 32'(rx_valid), 1);
    chk("ovr_pulse_once", 32'(ovr_seen - o0), 1);
    chk("ovr_one_frame", 32'(frames_seen - f0), 1);
    rx_ready = 1'b1;
    @(negedge clk);
    chk("ovr_consumed", 32'(rx_valid), 0);

    // Reset in the middle of 0x5A's data bits, then a clean 0x3C.
    f0 = frames_seen;
    bit_time(1'b0); bit_time(1'b0); bit_time(1'b1); bit_time(1'b0);
    rst = 1'b1; rxd = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_mid_busy", 32'(rx_busy), 0);
    chk("rst_mid_valid", 32'(rx_valid), 0);
    repeat (64) @(negedge clk);
    push(8'h3C, 1'b0, 1'b0);
    send(8'h3C, 8, 1'b0, 1'b0, 1'b1);
    rxd = 1'b1;
    repeat (64) @(negedge clk);
    chk("rst_mid_one_frame", 32'(frames_seen - f0), 1);
    chk("rst_mid_data", 32'(rx_data), 32'h3C);

    for (int i = 0; i < 1000 && sb.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- 16x-oversampled UART receiver; consumes the one-clock `rx_tick` strobe from the baud-rate generator.
- Recovers 5–8 bit frames from the asynchronous serial line: start bit, data LSB first, optional parity, 1 stop bit.
- Delivers each byte to the APB register/FIFO side over a valid/ready handshake, with parity, framing and overrun flags.

Parameters:
- DATA_WIDTH, 8, width of `rx_data` and of the shift register.
- OVERSAMPLE, 16, `rx_tick` strobes per bit period.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_tick  in  1  oversample strobe, one clk wide
- rxd  in  1  asynchronous serial input, idle high
- cfg_data_bits  in  2  00=5, 01=6, 10=7, 11=8 data bits
- cfg_parity_en  in  1  1 = parity bit present
- cfg_parity_odd  in  1  1 = odd parity, 0 = even
- rx_ready  in  1  consumer accepts `rx_data`
- rx_valid  out  1  `rx_data` and flags valid
- rx_data  out  DATA_WIDTH  received data, right-aligned, unused MSBs 0
- parity_err  out  1  parity mismatch for current `rx_data`
- frame_err  out  1  stop bit sampled 0 for current `rx_data`
- overrun_err  out  1  one-clk pulse: frame completed while `rx_valid` was high
- rx_busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (synchronous, active-high):
  - outputs: `rx_valid`, `rx_data`, `parity_err`, `frame_err`, `overrun_err`, `rx_busy` = 0.
  - internal: synchronizer flops = 1, state = IDLE, tick counter = 0.
  - Reset mid-frame aborts the frame silently; no flags.
- Input sync: `rxd` passes through a 2-FF synchronizer; all logic uses the synced value `rxs`.
- All counting and sampling happens only on clk edges where `rx_tick` = 1. Tick counter is 4 bits and wraps 15 -> 0.
- FSM states: IDLE, START, DATA, PARITY, STOP, WAIT_IDLE.
- IDLE:
  - `rxs` = 0 on a tick -> START, counter = 0.
- START:
  - On the tick where counter = 7 (mid-bit): if `rxs` = 0 -> DATA, counter = 0, bit index = 0.
  - Otherwise it is a false start (glitch) -> IDLE, no flags.
- DATA:
  - On the tick where counter = 15, shift `rxs` into the shift register (LSB first).
  - After bit index = N-1 (N from `cfg_data_bits`): go to PARITY if `cfg_parity_en`, else STOP.
- PARITY:
  - Sample at counter = 15.
  - Error when the XOR of data bits and the parity bit ≠ `cfg_parity_odd`.
- STOP:
  - Sample at counter = 15, then complete the frame. Return to IDLE if stop = 1, else WAIT_IDLE.
- WAIT_IDLE: stay until `rxs` = 1 on a tick -> IDLE. This prevents break conditions from retriggering.
- Frame completion (same clk as the stop sample):
  - If `rx_valid` = 0: next clk load `rx_data`, `parity_err`, `frame_err`, and set `rx_valid` = 1. Latency is 1 clk after the stop-sample tick.
  - If `rx_valid` = 1 (unread data): new frame dropped, held data and flags unchanged, `overrun_err` pulses 1 clk.
- Handshake:
  - `rx_valid` stays high until `rx_valid` && `rx_ready`; the next clk clears it.
  - If the clear and a frame completion happen on the same clk, the completion wins: new data loads, `rx_valid` stays 1, no overrun.
- `rx_data` holds its value after consumption until the next load.
- Config inputs must be static while `rx_busy` = 1; they are sampled when leaving IDLE.

Decomposition:
- Shared package `uart_pkg`:
  - state enum typedef `uart_rx_state_t`
  - localparams: OVERSAMPLE, mid-start count 7, sample count 15
  - `cfg_data_bits` encoding constants, shared with the future `uart_tx`
- Sub-module `uart_sync2`: 2-FF synchronizer, reset value parameterised (1 here).

Test Plan (bench drives `rx_tick` as a 1-in-4 clk strobe, so 64 clk per bit):
- 8N1, send 0xA5 -> `rx_valid` rises 1 clk after the stop-sample tick, `rx_data` = 0xA5, no flags. With `rx_ready` = 1, `rx_valid` drops next clk.
- 7E1, send 0x35 with correct parity bit 0 -> `rx_data` = 0x35, `parity_err` = 0. Resend with parity bit 1 -> `rx_data` = 0x35, `parity_err` = 1.
- 8N1, `rxd` low for 5 ticks then high -> no `rx_valid`, FSM returns to IDLE, `rx_busy` falls.
- 8N1, send 0x00 with stop bit 0, line held low 40 ticks -> `frame_err` = 1, `rx_data` = 0x00, no second frame until `rxd` returns high.
- `rx_ready` = 0, send 0x11 then 0x22 back-to-back -> `rx_data` stays 0x11, `overrun_err` pulses once at 0x22's stop sample.
- Assert `rst` mid-data of 0x5A, release, send 0x3C -> only one frame reported, `rx_data` = 0x3C.
